ni_flit_injector: RTL and testbench

- Local-port network-interface injector for the VC-based mesh router.
- Accepts packet requests and payload words from the attached core, segments them into header/body/tail flits, and tags each flit with a one-hot VC ID.
- Drives the router's local input flit and write-enable pair, and consumes the router's local output credit vector.
- Keeps per-VC credit counters so it never overflows a router input VC buffer.

---
 rtl/ni_flit_injector.sv | 176 +++++++++++++++++
 tb/tb_ni_flit_injector.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_flit_injector.sv
`default_nettype none
// ============================================================================
// Module   : ni_flit_injector
// Brief    : Network-interface injector; segments core packets into
//            header/body/tail flits on a round-robin VC with per-VC credits.
// Revision : 1.0 - initial release
// ============================================================================
module ni_flit_injector #(
    parameter int VC_NUM_PER_PORT   = 2,
    parameter int BUFFER_NUM_PER_VC = 4,
    parameter int PYLD_WIDTH        = 10,
    parameter int FLIT_TYPE_WIDTH   = 2,
    parameter int X_ADDR_WIDTH      = 2,
    parameter int Y_ADDR_WIDTH      = 2,
    parameter int SW_X_ADDR         = 2,
    parameter int SW_Y_ADDR         = 1,
    parameter int LEN_WIDTH         = 4,
    parameter int FLIT_WIDTH        = PYLD_WIDTH + FLIT_TYPE_WIDTH + VC_NUM_PER_PORT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pkt_req,
    input  logic [X_ADDR_WIDTH-1:0]    pkt_dest_x,
    input  logic [Y_ADDR_WIDTH-1:0]    pkt_dest_y,
    input  logic [LEN_WIDTH-1:0]       pkt_len,
    output logic                       pkt_ack,
    input  logic [PYLD_WIDTH-1:0]      data_in,
    input  logic                       data_valid,
    output logic                       data_ready,
    output logic [FLIT_WIDTH-1:0]      flit_out,
    output logic                       wr_out,
    input  logic [VC_NUM_PER_PORT-1:0] credit_in,
    output logic                       busy,
    output logic                       credit_err
);

    localparam int c_vc_idx_w = (VC_NUM_PER_PORT > 1) ? $clog2(VC_NUM_PER_PORT) : 1;
    localparam int c_cred_w   = $clog2(BUFFER_NUM_PER_VC + 1);

    localparam logic [c_cred_w-1:0]        c_cred_max   = c_cred_w'(BUFFER_NUM_PER_VC);
    localparam logic [c_vc_idx_w-1:0]      c_vc_last    = c_vc_idx_w'(VC_NUM_PER_PORT - 1);
    localparam logic [X_ADDR_WIDTH-1:0]    c_src_x      = X_ADDR_WIDTH'(SW_X_ADDR);
    localparam logic [Y_ADDR_WIDTH-1:0]    c_src_y      = Y_ADDR_WIDTH'(SW_Y_ADDR);
    localparam logic [FLIT_TYPE_WIDTH-1:0] c_type_body  = FLIT_TYPE_WIDTH'(0);
    localparam logic [FLIT_TYPE_WIDTH-1:0] c_type_tail  = FLIT_TYPE_WIDTH'(1);
    localparam logic [FLIT_TYPE_WIDTH-1:0] c_type_hdr   = FLIT_TYPE_WIDTH'(2);
    localparam logic [FLIT_TYPE_WIDTH-1:0] c_type_single = FLIT_TYPE_WIDTH'(3);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_body = 1'b1;

    logic [0:0]                 r_state;
    logic [0:0]                 w_state_next;
    logic [c_cred_w-1:0]        r_credit [VC_NUM_PER_PORT];
    logic [c_vc_idx_w-1:0]      r_rr_ptr;
    logic [c_vc_idx_w-1:0]      r_vc;
    logic [LEN_WIDTH-1:0]       r_remaining;
    logic [FLIT_WIDTH-1:0]      r_flit;
    logic                       r_wr;
    logic                       r_ack;
    logic                       r_credit_err;

    logic [c_vc_idx_w-1:0]      w_sel_vc;
    logic [c_vc_idx_w-1:0]      w_idx;
    logic                       w_sel_found;
    logic                       w_hdr_fire;
    logic                       w_body_fire;
    logic                       w_send;
    logic                       w_tail;
    logic                       w_single;
    logic [c_vc_idx_w-1:0]      w_send_vc;
    logic [VC_NUM_PER_PORT-1:0] w_send_oh;
    logic [VC_NUM_PER_PORT-1:0] w_dec;
    logic [VC_NUM_PER_PORT-1:0] w_ovf;
    logic [PYLD_WIDTH-1:0]      w_hdr_pyld;

    // Round-robin search begins at the VC after the last one used.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_vc    = '0;
        w_idx       = '0;
        for (int i = 0; i < VC_NUM_PER_PORT; i++) begin
            w_idx = (int'(r_rr_ptr) + i >= VC_NUM_PER_PORT) ?
                    c_vc_idx_w'(int'(r_rr_ptr) + i - VC_NUM_PER_PORT) :
                    c_vc_idx_w'(int'(r_rr_ptr) + i);
            if (!w_sel_found && (r_credit[w_idx] != '0)) begin
                w_sel_found = 1'b1;
                w_sel_vc    = w_idx;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_hdr_fire && !w_single) w_state_next = c_st_body;
            c_st_body: if (w_body_fire && w_tail)   w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_single    = (pkt_len == LEN_WIDTH'(1));
        w_tail      = (r_remaining == LEN_WIDTH'(1));
        w_hdr_fire  = (r_state == c_st_idle) && pkt_req && (pkt_len != '0) && w_sel_found;
        data_ready  = (r_state == c_st_body) && (r_credit[r_vc] != '0);
        w_body_fire = data_ready && data_valid;
        busy        = (r_state == c_st_body);
        w_send      = w_hdr_fire || w_body_fire;
        w_send_vc   = w_hdr_fire ? w_sel_vc : r_vc;
        w_hdr_pyld  = PYLD_WIDTH'({c_src_x, c_src_y, pkt_dest_x, pkt_dest_y});
        for (int v = 0; v < VC_NUM_PER_PORT; v++) begin
            w_send_oh[v] = (w_send_vc == c_vc_idx_w'(v));
            w_dec[v]     = w_send && w_send_oh[v];
            w_ovf[v]     = credit_in[v] && !w_dec[v] && (r_credit[v] == c_cred_max);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flit      <= '0;
            r_wr        <= 1'b0;
            r_ack       <= 1'b0;
            r_vc        <= '0;
            r_rr_ptr    <= '0;
            r_remaining <= '0;
        end else begin
            r_wr  <= w_send;
            r_ack <= w_hdr_fire;
            if (w_hdr_fire) begin
                r_flit      <= {(w_single ? c_type_single : c_type_hdr), w_send_oh, w_hdr_pyld};
                r_vc        <= w_sel_vc;
                r_rr_ptr    <= (w_sel_vc == c_vc_last) ? '0 : w_sel_vc + 1'b1;
                r_remaining <= pkt_len - 1'b1;
            end else if (w_body_fire) begin
                r_flit      <= {(w_tail ? c_type_tail : c_type_body), w_send_oh, data_in};
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    // Simultaneous send and return on one VC cancel; a return to a full counter is an error.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < VC_NUM_PER_PORT; v++) r_credit[v] <= c_cred_max;
            r_credit_err <= 1'b0;
        end else begin
            for (int v = 0; v < VC_NUM_PER_PORT; v++) begin
                if (credit_in[v] && !w_dec[v]) begin
                    if (r_credit[v] != c_cred_max) r_credit[v] <= r_credit[v] + 1'b1;
                end else if (w_dec[v] && !credit_in[v]) begin
                    r_credit[v] <= r_credit[v] - 1'b1;
                end
            end
            r_credit_err <= r_credit_err | (|w_ovf);
        end
    end

    assign flit_out   = r_flit;
    assign wr_out     = r_wr;
    assign pkt_ack    = r_ack;
    assign credit_err = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_ni_flit_injector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ni_flit_injector
// Brief    : Directed plus randomized bench with a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ni_flit_injector;

    localparam int VC  = 2;
    localparam int BUF = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pkt_req = 1'b0;
    logic [1:0]  pkt_dest_x = '0;
    logic [1:0]  pkt_dest_y = '0;
    logic [3:0]  pkt_len = '0;
    logic [9:0]  data_in = '0;
    logic        data_valid = 1'b0;
    logic [1:0]  credit_in = '0;
    logic        pkt_ack, data_ready, wr_out, busy, credit_err;
    logic [13:0] flit_out;

    int total = 0;
    int bad   = 0;

    // Model: packet progress as plain counters, credits as integers.
    int          m_cred [VC];
    bit          m_in_pkt, m_err, m_wr, m_ack;
    int          m_vc, m_left, m_next;
    logic [13:0] m_flit;

    ni_flit_injector dut (
        .clk(clk), .reset(reset), .pkt_req(pkt_req), .pkt_dest_x(pkt_dest_x),
        .pkt_dest_y(pkt_dest_y), .pkt_len(pkt_len), .pkt_ack(pkt_ack),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .flit_out(flit_out), .wr_out(wr_out), .credit_in(credit_in),
        .busy(busy), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] mk_flit(int typ, int vc, int pyld);
        return 14'((typ << 12) | ((1 << vc) << 10) | (pyld & 1023));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int sv;
        int v;
        sv = -1;
        if (reset) begin
            m_flit = '0; m_wr = 0; m_ack = 0; m_err = 0;
            m_in_pkt = 0; m_next = 0; m_vc = 0; m_left = 0;
            for (int k = 0; k < VC; k++) m_cred[k] = BUF;
            return;
        end
        m_wr  = 0;
        m_ack = 0;
        if (!m_in_pkt) begin
            if (pkt_req && pkt_len != 0) begin
                for (int k = 0; k < VC; k++) begin
                    v = (m_next + k) % VC;
                    if (sv < 0 && m_cred[v] > 0) sv = v;
                end
                if (sv >= 0) begin
                    m_flit = mk_flit((pkt_len == 1) ? 3 : 2, sv,
                                     2 * 64 + 1 * 16 + int'(pkt_dest_x) * 4 + int'(pkt_dest_y));
                    m_wr = 1; m_ack = 1;
                    m_next = (sv + 1) % VC;
                    if (pkt_len > 1) begin
                        m_in_pkt = 1; m_vc = sv; m_left = int'(pkt_len) - 1;
                    end
                end
            end
        end else if (data_valid && m_cred[m_vc] > 0) begin
            sv = m_vc;
            m_flit = mk_flit((m_left == 1) ? 1 : 0, sv, int'(data_in));
            m_wr = 1;
            m_left--;
            if (m_left == 0) m_in_pkt = 0;
        end
        for (int k = 0; k < VC; k++) begin
            if (credit_in[k] && sv != k) begin
                if (m_cred[k] == BUF) m_err = 1;
                else m_cred[k]++;
            end else if (!credit_in[k] && sv == k) begin
                m_cred[k]--;
            end
        end
    endtask

    // One clock: advance the model on the current inputs, then compare at the falling edge.
    task automatic cycle();
        bit m_ready;
        model_step();
        @(posedge clk);
        @(negedge clk);
        m_ready = m_in_pkt && (m_cred[m_vc] > 0);
        chk("wr_out", 32'(wr_out), 32'(m_wr));
        chk("pkt_ack", 32'(pkt_ack), 32'(m_ack));
        chk("flit_out", 32'(flit_out), 32'(m_flit));
        chk("data_ready", 32'(data_ready), 32'(m_ready));
        chk("busy", 32'(busy), 32'(m_in_pkt));
        chk("credit_err", 32'(credit_err), 32'(m_err));
    endtask

    task automatic do_reset();
        reset = 1; pkt_req = 0; data_valid = 0; credit_in = '0;
        cycle();
        reset = 0;
    endtask

    task automatic request(int len);
        pkt_req = 1; pkt_dest_x = 2'd3; pkt_dest_y = 2'd2; pkt_len = 4'(len);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        chk("rst_flit", 32'(flit_out), 32'h0);
        chk("rst_wr", 32'(wr_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Single-flit packet
        request(1);
        cycle();
        pkt_req = 0;
        chk("t1_flit", 32'(flit_out), 32'h349E);
        chk("t1_ack", 32'(pkt_ack), 32'h1);
        chk("t1_cred0", 32'(m_cred[0]), 32'd3);
        cycle();
        chk("t1_ack_pulse", 32'(pkt_ack), 32'h0);

        // Three-flit packet
        do_reset();
        request(3);
        cycle();
        pkt_req = 0;
        chk("t2_hdr", 32'(flit_out), 32'h249E);
        chk("t2_busy1", 32'(busy), 32'h1);
        data_valid = 1; data_in = 10'h155;
        cycle();
        chk("t2_body", 32'(flit_out), 32'h0555);
        chk("t2_busy2", 32'(busy), 32'h1);
        data_in = 10'h2AA;
        cycle();
        chk("t2_tail", 32'(flit_out), 32'h16AA);
        chk("t2_busy3", 32'(busy), 32'h0);
        data_valid = 0;

        // Credit exhaustion and a single returned credit
        do_reset();
        request(6);
        data_valid = 1; data_in = 10'h3C3;
        cycle();
        pkt_req = 0;
        for (int i = 0; i < 3; i++) cycle();
        chk("t3_wr4", 32'(wr_out), 32'h1);
        chk("t3_stall", 32'(data_ready), 32'h0);
        cycle();
        chk("t3_nowr", 32'(wr_out), 32'h0);
        credit_in = 2'b01;
        cycle();
        credit_in = 2'b00;
        chk("t3_ready", 32'(data_ready), 32'h1);
        cycle();
        chk("t3_wr5", 32'(wr_out), 32'h1);
        chk("t3_flit5", 32'(flit_out), 32'h07C3);
        chk("t3_stall2", 32'(data_ready), 32'h0);
        cycle();
        chk("t3_nowr2", 32'(wr_out), 32'h0);
        data_valid = 0;

        // Back-to-back packets rotate VCs
        do_reset();
        request(2);
        data_valid = 1; data_in = 10'h011;
        cycle();
        chk("t4_hdr1", 32'(flit_out), 32'h249E);
        cycle();
        chk("t4_tail1", 32'(flit_out), 32'h1411);
        cycle();
        pkt_req = 0;
        chk("t4_hdr2", 32'(flit_out), 32'h289E);
        chk("t4_ack2", 32'(pkt_ack), 32'h1);
        cycle();
        chk("t4_tail2", 32'(flit_out), 32'h1811);
        data_valid = 0;

        // Credit cancel on send and overflow detection
        do_reset();
        request(3);
        data_valid = 1; data_in = 10'h0AB;
        cycle();
        pkt_req = 0;
        credit_in = 2'b01;
        cycle();
        chk("t5_cred0", 32'(m_cred[0]), 32'd3);
        chk("t5_noerr", 32'(credit_err), 32'h0);
        credit_in = 2'b10;
        cycle();
        credit_in = 2'b00;
        chk("t5_err", 32'(credit_err), 32'h1);
        chk("t5_cred1", 32'(m_cred[1]), 32'd4);
        data_valid = 0;

        // Reset mid-packet
        do_reset();
        request(4);
        data_valid = 1; data_in = 10'h123;
        cycle();
        pkt_req = 0;
        cycle();
        reset = 1;
        cycle();
        reset = 0; data_valid = 0;
        chk("t6_wr", 32'(wr_out), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        request(2);
        cycle();
        pkt_req = 0;
        chk("t6_hdr", 32'(flit_out), 32'h249E);
        chk("t6_cred", 32'(m_cred[0] * 10 + m_cred[1]), 32'd34);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if (pkt_req && (m_ack || (pkt_len == 0 && $urandom_range(3) == 0))) pkt_req = 0;
            else if (!pkt_req && $urandom_range(3) == 0) begin
                pkt_req    = 1;
                pkt_dest_x = 2'($urandom);
                pkt_dest_y = 2'($urandom);
                pkt_len    = 4'($urandom_range(7));
            end
            data_valid = ($urandom_range(9) < 7);
            data_in    = 10'($urandom);
            for (int v = 0; v < VC; v++)
                credit_in[v] = (m_cred[v] < BUF && $urandom_range(2) == 0) || ($urandom_range(499) == 0);
            reset = ($urandom_range(399) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
